// File: rtl/apb_req_master_pkg.sv
// Shared types for the APB request master: FSM states, request/response records
// and the byte-lane alignment width derived from the APB data width.
package apb_req_master_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int ALIGN_WIDTH    = $clog2(APB_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } apb_resp_t;

    // A request is misaligned when any byte-offset bit below the bus word is set.
    function automatic logic is_misaligned(input logic [APB_ADDR_WIDTH-1:0] addr);
        return addr[ALIGN_WIDTH-1:0] != '0;
    endfunction

endpackage

// File: rtl/apb_req_master_timeout.sv
// ACCESS-phase watchdog counter; only instantiated when APB_REQ_MASTER_TIMEOUT_EN
// is defined. expire_o flags the enabled cycle in which the count reaches TERMINAL.
module apb_timeout_cnt #(
    parameter int TERMINAL = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TERMINAL + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire_o = enable_i && (count_q == CNT_W'(TERMINAL - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_req_master.sv
// Valid/ready request channel to APB master bridge, one transfer outstanding.
// Optional ACCESS timeout is enabled by defining APB_REQ_MASTER_TIMEOUT_EN.
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    // The request/response records are sized by the package; retarget widths there.
    if (ADDR_WIDTH != APB_ADDR_WIDTH || DATA_WIDTH != APB_DATA_WIDTH) begin : g_width_check
        $error("apb_req_master: ADDR/DATA_WIDTH must match apb_req_master_pkg");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("apb_req_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_e    state_q;
    apb_req_t  req_q;
    apb_resp_t resp_q;
    logic      psel_q;
    logic      penable_q;
    logic      resp_valid_q;
    logic      timeoutHit;

    assign req_ready_o  = (state_q == IDLE);
    assign paddr_o      = req_q.addr;
    assign pwrite_o     = req_q.write;
    assign pwdata_o     = req_q.wdata;
    assign psel_o       = psel_q;
    assign penable_o    = penable_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_q.rdata;
    assign resp_err_o   = resp_q.err;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    logic cntClear;
    logic cntEnable;

    // Cleared on the accept that enters SETUP; pready in the terminal cycle disables expiry.
    assign cntClear  = (state_q == IDLE) && req_valid_i && !is_misaligned(req_addr_i);
    assign cntEnable = (state_q == ACCESS) && !pready_i;

    apb_timeout_cnt #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .expire_o (timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            req_q        <= '0;
            resp_q       <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q.addr  <= req_addr_i;
                        req_q.write <= req_write_i;
                        req_q.wdata <= req_write_i ? req_wdata_i : '0;
                        // Misaligned requests never reach the bus and answer immediately.
                        if (is_misaligned(req_addr_i)) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_q       <= '{rdata: '0, err: 1'b1};
                        end else begin
                            state_q <= SETUP;
                            psel_q  <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready_i) begin
                        state_q      <= RESP;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_q.err   <= pslverr_i;
                        resp_q.rdata <= (!req_q.write && !pslverr_i) ? prdata_i : '0;
                    end else if (timeoutHit) begin
                        state_q      <= RESP;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_q       <= '{rdata: '0, err: 1'b1};
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed scoreboard bench for apb_req_master; the timeout scenarios run only
// when APB_REQ_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES is overridden to 8).
module tb_apb_req_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqWrite;
    logic [31:0] reqWdata;
    logic        respValid;
    logic        respReady;
    logic [31:0] respRdata;
    logic        respErr;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    exp_t sbQ[$];
    int   nChecks = 0;
    int   nFail   = 0;

    apb_req_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_addr_i   (reqAddr),
        .req_write_i  (reqWrite),
        .req_wdata_i  (reqWdata),
        .resp_valid_o (respValid),
        .resp_ready_i (respReady),
        .resp_rdata_o (respRdata),
        .resp_err_o   (respErr),
        .paddr_o      (paddr),
        .pwdata_o     (pwdata),
        .pwrite_o     (pwrite),
        .psel_o       (psel),
        .penable_o    (penable),
        .prdata_i     (prdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, and queue its expected response.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                 input bit expectResp, input logic [31:0] expRdata, input logic expErr);
        int n = 0;
        reqAddr  = addr;
        reqWrite = wr;
        reqWdata = wdata;
        reqValid = 1'b1;
        while (!reqReady && n < 20) begin
            step();
            n++;
        end
        checkOutput("req_ready_before_accept", 32'(reqReady), 32'd1);
        if (expectResp) sbQ.push_back('{rdata: expRdata, err: expErr});
        step();
        reqValid = 1'b0;
    endtask

    task automatic collectResp(input string tag, input int maxCycles);
        exp_t e;
        int   n = 0;
        respReady = 1'b1;
        while (!respValid && n < maxCycles) begin
            step();
            n++;
        end
        checkOutput({tag, "_resp_valid"}, 32'(respValid), 32'd1);
        if (respValid) begin
            if (sbQ.size() == 0) begin
                checkOutput({tag, "_sb_nonempty"}, 32'(sbQ.size()), 32'd1);
            end else begin
                e = sbQ.pop_front();
                checkOutput({tag, "_rdata"}, respRdata, e.rdata);
                checkOutput({tag, "_err"}, 32'(respErr), 32'(e.err));
            end
            step();
        end
        respReady = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        reqValid  = 1'b0;
        reqAddr   = '0;
        reqWrite  = 1'b0;
        reqWdata  = '0;
        respReady = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        step();
        step();
        checkOutput("rst_psel", 32'(psel), 32'd0);
        checkOutput("rst_penable", 32'(penable), 32'd0);
        checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
        checkOutput("rst_paddr", paddr, 32'd0);
        checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
        rst = 1'b0;
        step();

        // Write with zero-wait slave: SETUP t+1, ACCESS t+2, response t+3.
        pready = 1'b1;
        prdata = 32'h5A5A5A5A;
        applyStimulus(32'h1000, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        checkOutput("t1_setup_psel", 32'(psel), 32'd1);
        checkOutput("t1_setup_penable", 32'(penable), 32'd0);
        checkOutput("t1_paddr", paddr, 32'h1000);
        checkOutput("t1_pwrite", 32'(pwrite), 32'd1);
        checkOutput("t1_pwdata", pwdata, 32'hDEADBEEF);
        checkOutput("t1_req_ready_busy", 32'(reqReady), 32'd0);
        step();
        checkOutput("t1_access_psel", 32'(psel), 32'd1);
        checkOutput("t1_access_penable", 32'(penable), 32'd1);
        step();
        checkOutput("t1_resp_valid_t3", 32'(respValid), 32'd1);
        checkOutput("t1_psel_drop", 32'(psel), 32'd0);
        checkOutput("t1_penable_drop", 32'(penable), 32'd0);
        collectResp("t1", 2);
        checkOutput("t1_idle_ready", 32'(reqReady), 32'd1);
        checkOutput("t1_idle_resp_valid", 32'(respValid), 32'd0);

        // Read with three wait states; write data bus forced to zero for reads.
        pready = 1'b0;
        prdata = 32'h12345678;
        applyStimulus(32'h2004, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h12345678, 1'b0);
        checkOutput("t2_pwdata_zero", pwdata, 32'h0);
        checkOutput("t2_pwrite", 32'(pwrite), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_penable_wait", 32'(penable), 32'd1);
            step();
        end
        checkOutput("t2_penable_last", 32'(penable), 32'd1);
        pready = 1'b1;
        step();
        checkOutput("t2_resp_valid", 32'(respValid), 32'd1);
        collectResp("t2", 2);

        // Slave error on read: err set, data zeroed.
        pslverr = 1'b1;
        prdata  = 32'hAAAA5555;
        applyStimulus(32'h3000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        collectResp("t3", 6);
        pslverr = 1'b0;

        // Misaligned read: immediate error response, bus untouched.
        applyStimulus(32'h4002, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        checkOutput("t4_psel", 32'(psel), 32'd0);
        checkOutput("t4_resp_valid_t1", 32'(respValid), 32'd1);
        collectResp("t4", 1);

        // Back-pressured response while a new request waits upstream.
        prdata = 32'hCAFEF00D;
        applyStimulus(32'h5000, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
        step();
        step();
        reqAddr  = 32'h6000;
        reqWrite = 1'b1;
        reqWdata = 32'h0BADC0DE;
        reqValid = 1'b1;
        sbQ.push_back('{rdata: 32'h0, err: 1'b0});
        for (int i = 0; i < 10; i++) begin
            checkOutput("t5_hold_valid", 32'(respValid), 32'd1);
            checkOutput("t5_hold_rdata", respRdata, 32'hCAFEF00D);
            checkOutput("t5_hold_req_ready", 32'(reqReady), 32'd0);
            step();
        end
        collectResp("t5a", 1);
        checkOutput("t5_ready_after_hs", 32'(reqReady), 32'd1);
        step();
        reqValid = 1'b0;
        checkOutput("t5_second_psel", 32'(psel), 32'd1);
        checkOutput("t5_second_paddr", paddr, 32'h6000);
        checkOutput("t5_second_pwdata", pwdata, 32'h0BADC0DE);
        collectResp("t5b", 6);

        // Reset in ACCESS: bus drops at the reset edge, no response follows.
        pready = 1'b0;
        applyStimulus(32'h7000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        checkOutput("t6_access_psel", 32'(psel), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t6_rst_psel", 32'(psel), 32'd0);
        checkOutput("t6_rst_penable", 32'(penable), 32'd0);
        for (int i = 0; i < 5; i++) step();
        checkOutput("t6_no_resp", 32'(respValid), 32'd0);
        checkOutput("t6_req_ready", 32'(reqReady), 32'd1);

`ifdef APB_REQ_MASTER_TIMEOUT_EN
        // Stalled slave: abort after 8 ACCESS cycles.
        applyStimulus(32'h8000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            checkOutput("t7_access_psel", 32'(psel), 32'd1);
            step();
        end
        checkOutput("t7_abort_psel", 32'(psel), 32'd0);
        checkOutput("t7_abort_resp_valid", 32'(respValid), 32'd1);
        collectResp("t7", 1);

        // pready in the terminal cycle completes normally.
        prdata = 32'h11112222;
        applyStimulus(32'h9000, 1'b0, 32'h0, 1'b1, 32'h11112222, 1'b0);
        step();
        for (int i = 0; i < 7; i++) step();
        checkOutput("t8_terminal_psel", 32'(psel), 32'd1);
        pready = 1'b1;
        step();
        checkOutput("t8_resp_valid", 32'(respValid), 32'd1);
        collectResp("t8", 1);
        pready = 1'b0;
`else
        // Without the watchdog, ACCESS waits as long as the slave stalls.
        prdata = 32'h0F0F0F0F;
        applyStimulus(32'h8000, 1'b0, 32'h0, 1'b1, 32'h0F0F0F0F, 1'b0);
        step();
        for (int i = 0; i < 20; i++) step();
        checkOutput("t7_long_wait_penable", 32'(penable), 32'd1);
        checkOutput("t7_long_wait_resp", 32'(respValid), 32'd0);
        pready = 1'b1;
        step();
        collectResp("t7", 1);
        pready = 1'b0;
`endif

        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
